// File: rtl/ld3320_cmd_sequencer.sv
// Command-ROM walker for the LD3320 voice chip: fetches register operations
// and hands them one at a time to the parallel-bus engine.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | rom_addr presented, waiting one cycle for ROM data
// DECODE    | command word latched, dispatch on op code
// ISSUE     | one-cycle strobe to the bus engine
// WAIT_DONE | waiting for bus_done, bounded by DONE_TMO
// DELAY     | millisecond wait or inter-poll gap (down-counter)
// NEXT      | advance rom_addr, or flag ROM overrun at the last entry
// FINISH    | seq_done pulse, back to IDLE
// ERROR     | raise sticky error, back to IDLE
module ld3320_cmd_sequencer #(
   parameter int ROM_AW     = 6,
   parameter int DELAY_UNIT = 50000,
   parameter int POLL_MAX   = 255,
   parameter int POLL_GAP   = 1000,
   parameter int DONE_TMO   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ROM_AW-1:0] start_addr,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [18:0]       rom_data,
   output logic              bus_ena,
   output logic              bus_sel,
   output logic [7:0]        bus_address,
   output logic [7:0]        bus_data,
   input  logic [7:0]        bus_rdata,
   input  logic              bus_rready,
   input  logic              bus_done,
   output logic              busy,
   output logic              seq_done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [7:0]        rd_data,
   output logic              rd_valid
);

   localparam logic [2:0] OP_WRITE = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_DELAY = 3'd2;
   localparam logic [2:0] OP_POLL  = 3'd3;

   localparam int DLY_MAX = (255 * DELAY_UNIT > POLL_GAP) ? 255 * DELAY_UNIT : POLL_GAP;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam int TMO_W   = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE,
      S_DELAY, S_NEXT, S_FINISH, S_ERROR
   } state_t;

   state_t           state, state_next;
   logic [2:0]       cmd_op;
   logic [DLY_W-1:0] dly_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       poll_cnt;
   logic [7:0]       rdata_cap;
   logic [7:0]       rdata_eff;
   logic [2:0]       dec_op;
   logic [7:0]       dec_arg;
   logic             poll_hit;
   logic             poll_last;
   logic             rom_last;

   assign dec_op    = rom_data[18:16];
   assign dec_arg   = rom_data[7:0];
   // Read data may arrive with bus_done or ahead of it.
   assign rdata_eff = bus_rready ? bus_rdata : rdata_cap;
   assign poll_hit  = (rdata_eff & bus_data) == bus_data;
   assign poll_last = ({1'b0, poll_cnt} + 9'd1) >= 9'(POLL_MAX);
   assign rom_last  = &rom_addr;
   assign bus_ena   = (state == S_ISSUE);
   assign seq_done  = (state == S_FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_FETCH;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (dec_op)
               OP_WRITE, OP_READ, OP_POLL: state_next = S_ISSUE;
               OP_DELAY: state_next = (dec_arg == 8'd0) ? S_NEXT : S_DELAY;
               default:  state_next = S_FINISH;
            endcase
         end
         S_ISSUE:  state_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus_done) begin
               if (cmd_op == OP_POLL && !poll_hit)
                  state_next = poll_last ? S_ERROR : S_DELAY;
               else
                  state_next = S_NEXT;
            end else if (tmo_cnt == '0) begin
               state_next = S_ERROR;
            end
         end
         S_DELAY:  if (dly_cnt == '0) state_next = (cmd_op == OP_POLL) ? S_ISSUE : S_NEXT;
         S_NEXT:   state_next = rom_last ? S_ERROR : S_FETCH;
         S_FINISH: state_next = S_IDLE;
         S_ERROR:  state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr    <= '0;
         cmd_op      <= '0;
         bus_sel     <= 1'b0;
         bus_address <= '0;
         bus_data    <= '0;
         dly_cnt     <= '0;
         tmo_cnt     <= '0;
         poll_cnt    <= '0;
         rdata_cap   <= '0;
         busy        <= 1'b0;
         error       <= 1'b0;
         err_code    <= 2'b00;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  rom_addr <= start_addr;
                  busy     <= 1'b1;
                  error    <= 1'b0;
                  err_code <= 2'b00;
               end
            end
            S_DECODE: begin
               cmd_op      <= dec_op;
               bus_address <= rom_data[15:8];
               bus_data    <= dec_arg;
               bus_sel     <= (dec_op == OP_WRITE);
               poll_cnt    <= '0;
               if (dec_op == OP_DELAY && dec_arg != 8'd0)
                  dly_cnt <= DLY_W'(dec_arg) * DLY_W'(DELAY_UNIT) - DLY_W'(1);
            end
            S_ISSUE: tmo_cnt <= TMO_W'(DONE_TMO - 1);
            S_WAIT_DONE: begin
               if (bus_rready) rdata_cap <= bus_rdata;
               if (bus_done) begin
                  if (cmd_op == OP_READ) begin
                     rd_data  <= rdata_eff;
                     rd_valid <= 1'b1;
                  end else if (cmd_op == OP_POLL && !poll_hit) begin
                     poll_cnt <= poll_cnt + 8'd1;
                     if (poll_last) err_code <= 2'b10;
                     else           dly_cnt  <= DLY_W'(POLL_GAP - 1);
                  end
               end else if (tmo_cnt == '0) begin
                  err_code <= 2'b01;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_W'(1);
               end
            end
            S_DELAY: if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
            S_NEXT: begin
               if (rom_last) err_code <= 2'b11;
               else          rom_addr <= rom_addr + ROM_AW'(1);
            end
            S_FINISH: busy <= 1'b0;
            S_ERROR: begin
               busy  <= 1'b0;
               error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ld3320_cmd_sequencer.sv
// Scoreboard bench for ld3320_cmd_sequencer: a sequence-level model predicts
// bus strobes, read results and the final outcome; a monitor checks them.
module tb_ld3320_cmd_sequencer;

   localparam int ROM_AW     = 6;
   localparam int DELAY_UNIT = 10;
   localparam int POLL_MAX   = 3;
   localparam int POLL_GAP   = 5;
   localparam int DONE_TMO   = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ROM_AW-1:0] start_addr;
   logic [ROM_AW-1:0] rom_addr;
   logic [18:0]       rom_data;
   logic              bus_ena;
   logic              bus_sel;
   logic [7:0]        bus_address;
   logic [7:0]        bus_data;
   logic [7:0]        bus_rdata;
   logic              bus_rready;
   logic              bus_done;
   logic              busy;
   logic              seq_done;
   logic              error;
   logic [1:0]        err_code;
   logic [7:0]        rd_data;
   logic              rd_valid;

   ld3320_cmd_sequencer #(
      .ROM_AW(ROM_AW), .DELAY_UNIT(DELAY_UNIT), .POLL_MAX(POLL_MAX),
      .POLL_GAP(POLL_GAP), .DONE_TMO(DONE_TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .rom_addr(rom_addr), .rom_data(rom_data), .bus_ena(bus_ena),
      .bus_sel(bus_sel), .bus_address(bus_address), .bus_data(bus_data),
      .bus_rdata(bus_rdata), .bus_rready(bus_rready), .bus_done(bus_done),
      .busy(busy), .seq_done(seq_done), .error(error), .err_code(err_code),
      .rd_data(rd_data), .rd_valid(rd_valid)
   );

   logic [18:0] rom [64];
   logic [7:0]  eng_rd [$];
   int          eng_lat;
   logic        eng_mute;

   logic [16:0] exp_stb [$];
   logic [7:0]  exp_rd  [$];
   logic [3:0]  exp_end [$];
   int          stb_t   [$];
   int          end_cnt;
   int          end_t;
   int          cyc;
   int          total;
   int          bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   function automatic logic [18:0] cmd(input int op, input int a, input int d);
      return {3'(op), 8'(a), 8'(d)};
   endfunction

   // Bus engine: answers each strobe eng_lat cycles later.
   initial begin
      logic       sel;
      logic [7:0] rv;
      bus_done = 1'b0; bus_rready = 1'b0; bus_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst_n && bus_ena && !eng_mute) begin
            sel = bus_sel;
            repeat (eng_lat) @(posedge clk);
            #1;
            rv = 8'h00;
            if (!sel && eng_rd.size() != 0) rv = eng_rd.pop_front();
            bus_done = 1'b1; bus_rready = !sel; bus_rdata = rv;
            @(posedge clk); #1;
            bus_done = 1'b0; bus_rready = 1'b0;
         end
      end
   end

   // Monitor: compares everything the DUT presents against the queues.
   initial begin
      logic prev_busy, seq_seen;
      prev_busy = 1'b0; seq_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = 1'b0; seq_seen = 1'b0;
         end else begin
            if (bus_ena) begin
               stb_t.push_back(cyc);
               check("strobe_expected", exp_stb.size() != 0, 1);
               if (exp_stb.size() != 0)
                  check("strobe", {bus_sel, bus_address, bus_sel ? bus_data : 8'h00},
                        exp_stb.pop_front());
            end
            if (rd_valid) begin
               check("rd_expected", exp_rd.size() != 0, 1);
               if (exp_rd.size() != 0) check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (seq_done) seq_seen = 1'b1;
            if (prev_busy && !busy) begin
               check("end_expected", exp_end.size() != 0, 1);
               if (exp_end.size() != 0)
                  check("outcome", {seq_seen, error, err_code}, exp_end.pop_front());
               end_t = cyc;
               end_cnt++;
               seq_seen = 1'b0;
            end
            prev_busy = busy;
         end
      end
   end

   // Sequence-level reference: walks the ROM with the engine's response list.
   task automatic model_seq(input int a0);
      logic [7:0]  rq [$];
      logic [18:0] w;
      logic [7:0]  d;
      int          a, misses;
      rq = eng_rd;
      a  = a0;
      forever begin
         w = rom[a];
         case (w[18:16])
            3'd0, 3'd1, 3'd3: begin
               misses = 0;
               forever begin
                  exp_stb.push_back({w[18:16] == 3'd0, w[15:8], (w[18:16] == 3'd0) ? w[7:0] : 8'h00});
                  if (eng_mute) begin exp_end.push_back(4'b0101); return; end
                  if (w[18:16] == 3'd0) break;
                  d = (rq.size() != 0) ? rq.pop_front() : 8'h00;
                  if (w[18:16] == 3'd1) begin exp_rd.push_back(d); break; end
                  if ((d & w[7:0]) == w[7:0]) break;
                  misses++;
                  if (misses == POLL_MAX) begin exp_end.push_back(4'b0110); return; end
               end
            end
            3'd2: ;
            default: begin exp_end.push_back(4'b1000); return; end
         endcase
         if (a == 63) begin exp_end.push_back(4'b0111); return; end
         a++;
      end
   endtask

   task automatic pulse_start(input int a);
      @(posedge clk); #1;
      start = 1'b1; start_addr = ROM_AW'(a);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_seq(input int a, input bit poke);
      int n;
      exp_stb.delete(); exp_rd.delete(); exp_end.delete(); stb_t.delete();
      model_seq(a);
      n = end_cnt;
      pulse_start(a);
      if (poke) begin
         repeat (4) @(posedge clk);
         pulse_start(0);
      end
      for (int i = 0; i < 4000 && end_cnt == n; i++) @(posedge clk);
      check("seq_end", end_cnt - n, 1);
      check("leftover", exp_stb.size() + exp_rd.size() + exp_end.size(), 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] mask, lsb;
      int n, tries;
      total = 0; bad = 0; end_cnt = 0; end_t = 0; cyc = 0;
      rst_n = 1'b0; start = 1'b0; start_addr = '0;
      eng_lat = 2; eng_mute = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = cmd(4, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", {rom_addr, bus_ena, bus_sel, bus_address, bus_data, busy}, 0);
      check("reset_b", {seq_done, error, err_code, rd_data, rd_valid}, 0);
      rst_n = 1'b1;

      rom[0] = cmd(0, 8'h17, 8'h35); rom[1] = cmd(4, 0, 0);
      run_seq(0, 0);

      rom[4] = cmd(1, 8'h06, 0); rom[5] = cmd(4, 0, 0);
      eng_rd.delete(); eng_rd.push_back(8'h5A);
      run_seq(4, 0);

      rom[8]  = cmd(0, 8'h10, 8'h01); rom[9]  = cmd(2, 0, 3);
      rom[10] = cmd(0, 8'h11, 8'h02); rom[11] = cmd(2, 0, 0);
      rom[12] = cmd(0, 8'h12, 8'h03); rom[13] = cmd(5, 0, 0);
      run_seq(8, 0);
      check("delay3_gap", stb_t[1] - stb_t[0], eng_lat + 7 + 3 * DELAY_UNIT);
      check("delay0_gap", stb_t[2] - stb_t[1], eng_lat + 7);

      rom[16] = cmd(3, 8'hB7, 8'h21); rom[17] = cmd(4, 0, 0);
      eng_rd.delete(); eng_rd = '{8'h20, 8'h20, 8'h21};
      run_seq(16, 0);
      check("poll_strobes", stb_t.size(), 3);
      check("poll_gap1", stb_t[1] - stb_t[0], eng_lat + 1 + POLL_GAP);
      check("poll_gap2", stb_t[2] - stb_t[1], eng_lat + 1 + POLL_GAP);

      rom[20] = cmd(3, 8'h30, 8'h0F); rom[21] = cmd(4, 0, 0);
      eng_rd.delete(); eng_rd = '{8'h07, 8'h0E, 8'hF0};
      run_seq(20, 0);

      rom[24] = cmd(0, 8'h01, 8'h02); rom[25] = cmd(4, 0, 0);
      eng_mute = 1'b1;
      run_seq(24, 1);
      check("tmo_window", (end_t - stb_t[0] >= DONE_TMO + 1) && (end_t - stb_t[0] <= DONE_TMO + 3), 1);

      exp_stb.delete(); exp_rd.delete(); exp_end.delete(); stb_t.delete();
      exp_stb.push_back({1'b1, 8'h01, 8'h02});
      pulse_start(24);
      for (int i = 0; i < 50 && stb_t.size() == 0; i++) @(posedge clk);
      check("rst_strobe_seen", stb_t.size(), 1);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_a", {rom_addr, bus_ena, bus_sel, bus_address, bus_data, busy}, 0);
      check("midrst_b", {seq_done, error, err_code, rd_data, rd_valid}, 0);
      exp_stb.delete(); exp_rd.delete(); exp_end.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      eng_mute = 1'b0;

      rom[62] = cmd(0, 8'hA0, 8'h11); rom[63] = cmd(0, 8'hA1, 8'h22);
      run_seq(62, 0);
      run_seq(0, 0);

      for (int it = 0; it < 20; it++) begin
         eng_rd.delete();
         eng_lat = $urandom_range(1, 5);
         n = $urandom_range(2, 7);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0: rom[32 + i] = cmd(0, $urandom_range(0, 255), $urandom_range(0, 255));
               1: begin
                  rom[32 + i] = cmd(1, $urandom_range(0, 255), 0);
                  eng_rd.push_back(8'($urandom));
               end
               2: rom[32 + i] = cmd(2, $urandom_range(0, 255), $urandom_range(0, 2));
               default: begin
                  mask  = 8'($urandom_range(1, 255));
                  lsb   = mask & (~mask + 8'd1);
                  tries = $urandom_range(1, POLL_MAX + 1);
                  rom[32 + i] = cmd(3, $urandom_range(0, 255), mask);
                  for (int t = 1; t <= tries && t <= POLL_MAX; t++) begin
                     if (t < tries || tries > POLL_MAX) eng_rd.push_back(8'($urandom) & ~lsb);
                     else                               eng_rd.push_back(8'($urandom) | mask);
                  end
               end
            endcase
         end
         rom[32 + n] = cmd($urandom_range(4, 7), $urandom_range(0, 255), $urandom_range(0, 255));
         run_seq(32, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ld3320_cmd_sequencer.md
Name: ld3320_cmd_sequencer

Overview:
- Walks a command ROM of LD3320 register operations and drives the parallel-bus write/read engine one transaction at a time.
- Supported operations: write, read, millisecond delay, poll-until-mask.
- Sits between the voice-recognition top FSM (which requests init or recognition sequences by ROM start address) and the bus engine.
- Reports completion, read-back data and timeout/poll errors.

Parameters:
- ROM_AW, 6: command ROM address width; the ROM holds 2^ROM_AW entries.
- DELAY_UNIT, 50000: clk cycles per 1 ms delay unit.
- POLL_MAX, 255: maximum poll retries before error; 8-bit counter.
- POLL_GAP, 1000: idle clk cycles between poll reads.
- DONE_TMO, 16: clk cycles allowed from engine strobe to bus_done.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; honoured only when busy=0
- start_addr  in  ROM_AW  first command index
- rom_addr  out  ROM_AW  command ROM address
- rom_data  in  19  command word, valid one clk after rom_addr. Bits [18:16]=op, [15:8]=reg addr, [7:0]=data/mask/ms.
- bus_ena  out  1  one-cycle transaction strobe to the bus engine
- bus_sel  out  1  1=write, 0=read
- bus_address  out  8  LD3320 register address
- bus_data  out  8  write data
- bus_rdata  in  8  engine read data
- bus_rready  in  1  engine read data valid
- bus_done  in  1  engine completion pulse
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse on END
- error  out  1  sticky until next accepted start
- err_code  out  2  01=bus timeout, 10=poll exhausted, 11=ROM overrun
- rd_data  out  8  last READ result
- rd_valid  out  1  one-cycle pulse with rd_data

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters cleared.
- Reset mid-operation drops bus_ena immediately and abandons the sequence.
- Op codes:
  - 000 WRITE
  - 001 READ
  - 010 DELAY: data×DELAY_UNIT cycles; data=0 means no wait.
  - 011 POLL: read addr until (rdata & data)==data.
  - 100 END
  - 101–111: treated as END.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, NEXT, FINISH, ERROR.
- IDLE:
  - start → rom_addr<=start_addr, busy<=1, error<=0, err_code<=0, go to FETCH.
  - start while busy=1 is ignored.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE:
  - Latch the command.
  - WRITE/READ/POLL → ISSUE, with poll_cnt<=0.
  - DELAY → DELAY, or NEXT if ms=0.
  - END → FINISH.
- ISSUE:
  - bus_ena=1 for exactly one cycle.
  - bus_sel=1 for WRITE, 0 for READ/POLL.
  - bus_address/bus_data held stable from ISSUE until bus_done.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - bus_done for WRITE → NEXT.
  - bus_done for READ → rd_data<=bus_rdata, rd_valid pulse, then NEXT.
  - bus_done for POLL with match → NEXT.
  - bus_done for POLL without match → poll_cnt+1. If poll_cnt reaches POLL_MAX → ERROR (10); else DELAY for POLL_GAP cycles, then back to ISSUE.
  - No bus_done within DONE_TMO cycles → ERROR (01).
- DELAY:
  - Down-counter, width sufficient for 255×DELAY_UNIT.
  - Exits on reaching 0.
- NEXT:
  - If rom_addr == all-ones → ERROR (11); no wrap.
  - Else rom_addr+1 → FETCH.
- FINISH: seq_done pulse, busy<=0, go to IDLE.
- ERROR: error<=1, busy<=0, go to IDLE; error holds until the next accepted start.
- Timing: WRITE command-to-command latency is FETCH+DECODE+ISSUE+engine time+NEXT, i.e. 4 cycles plus engine time.

Test Plan:
- ROM[0]=WRITE 0x17/0x35, ROM[1]=END; start_addr=0 → one bus_ena with sel=1, addr 0x17, data 0x35; seq_done one cycle after NEXT→FINISH; busy low; error 0.
- ROM[4]=READ 0x06, ROM[5]=END; engine model returns 0x5A → rd_valid pulse with rd_data=0x5A, sel=0 on the strobe, then seq_done.
- DELAY ms=3 with DELAY_UNIT=10 → next bus_ena exactly 30 cycles after DELAY entry (+FETCH/DECODE overhead); ms=0 → no wait.
- POLL 0xB7 mask 0x21; model returns 0x20, 0x20, 0x21 → three strobes, each separated by POLL_GAP, then NEXT. With POLL_MAX=2 and never-matching data → error=1, err_code=10.
- Engine never returns bus_done → error=1, err_code=01 after DONE_TMO cycles. Start asserted while busy is ignored. rst_n low during WAIT_DONE → all outputs 0 asynchronously.
- No END before the last ROM entry → err_code=11. A subsequent start clears error and runs normally.
